// File: rtl/axi_slave_responder_if.sv
// AXI4 channel bundle between a NoC load generator (master) and the responder (slave).
// Latency: none, wires only.
// Backpressure: carried by the per-channel valid/ready pairs.
interface axi_slave_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_W_WIDTH = 5,
    parameter int ID_R_WIDTH = 5
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ID_W_WIDTH-1:0] aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;

    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_last;

    logic                  b_valid;
    logic                  b_ready;
    logic [ID_W_WIDTH-1:0] b_id;
    logic [1:0]            b_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ID_R_WIDTH-1:0] ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;

    logic                  r_valid;
    logic                  r_ready;
    logic [ID_R_WIDTH-1:0] r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len,
        output w_valid, w_data, w_last,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len,
        output r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp,
        input  ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len,
        input  w_valid, w_data, w_last,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len,
        input  r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp,
        output ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );
endinterface

// File: rtl/axi_slave_responder.sv
// AXI4 traffic sink: queues AW/AR, checks W pattern and length, returns in-order B and R bursts.
// Latency: W accepted 1 cycle after its AW; B valid 1 cycle after WLAST; R bursts back-to-back with no bubble.
// Backpressure: AW/AR stall when their queue is full; W stalls with no AW queued or B queue full.
module axi_slave_responder #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    ID_W_WIDTH   = 5,
    parameter int                    ID_R_WIDTH   = 5,
    parameter int                    FIFO_DEPTH   = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN_BASE = 'h30
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    axi_slave_responder_if.slave         s_axi,
    output logic [15:0]                  wr_cnt_o,
    output logic [15:0]                  rd_cnt_o,
    output logic                         wdata_err_o,
    output logic                         wlen_err_o,
    output logic                         idle_o
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int AWE = ID_W_WIDTH + ADDR_WIDTH + 8;
    localparam int ARE = ID_R_WIDTH + ADDR_WIDTH + 8;
    localparam int SW  = ADDR_WIDTH + 16;
    localparam logic [PW:0] PTR_ONE  = 1;
    localparam logic [PW:0] PTR_FULL = {1'b1, {PW{1'b0}}};

    typedef enum logic {R_IDLE, R_BURST} r_state_t;

    // Queue storage and wrap-bit pointers (full when only the wrap bit differs)
    logic [AWE-1:0]        aw_mem [FIFO_DEPTH];
    logic [ID_W_WIDTH-1:0] b_mem  [FIFO_DEPTH];
    logic [ARE-1:0]        ar_mem [FIFO_DEPTH];
    logic [PW:0]           aw_wp, aw_rp, b_wp, b_rp, ar_wp, ar_rp;
    logic                  aw_empty, aw_full, b_empty, b_full, ar_empty, ar_full;

    logic                  up_q;
    logic [7:0]            wcnt;
    logic [ID_W_WIDTH-1:0] awh_id;
    logic [ADDR_WIDTH-1:0] awh_addr;
    logic [7:0]            awh_len;
    logic [ID_R_WIDTH-1:0] arh_id;
    logic [ADDR_WIDTH-1:0] arh_addr;
    logic [7:0]            arh_len;
    logic [DATA_WIDTH-1:0] w_exp;

    r_state_t              state_q, state_d;
    logic                  ar_pop;
    logic [ID_R_WIDTH-1:0] r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q;
    logic [7:0]            beat_q;
    logic [SW-1:0]         r_sum;

    logic aw_push, w_fire, w_done, b_pop, ar_push, r_fire, r_done;

    assign aw_empty = (aw_wp == aw_rp);
    assign aw_full  = ((aw_wp ^ aw_rp) == PTR_FULL);
    assign b_empty  = (b_wp == b_rp);
    assign b_full   = ((b_wp ^ b_rp) == PTR_FULL);
    assign ar_empty = (ar_wp == ar_rp);
    assign ar_full  = ((ar_wp ^ ar_rp) == PTR_FULL);

    // Ready outputs stay low until the first clock after reset release
    assign s_axi.aw_ready = up_q && !aw_full;
    assign s_axi.w_ready  = !aw_empty && !b_full;
    assign s_axi.ar_ready = up_q && !ar_full;
    assign s_axi.b_valid  = !b_empty;
    assign s_axi.b_id     = b_mem[b_rp[PW-1:0]];
    assign s_axi.b_resp   = 2'b00;

    assign aw_push = s_axi.aw_valid && s_axi.aw_ready;
    assign w_fire  = s_axi.w_valid && s_axi.w_ready;
    assign w_done  = w_fire && s_axi.w_last;
    assign b_pop   = s_axi.b_valid && s_axi.b_ready;
    assign ar_push = s_axi.ar_valid && s_axi.ar_ready;
    assign r_fire  = s_axi.r_valid && s_axi.r_ready;
    assign r_done  = r_fire && s_axi.r_last;

    assign {awh_id, awh_addr, awh_len} = aw_mem[aw_rp[PW-1:0]];
    assign {arh_id, arh_addr, arh_len} = ar_mem[ar_rp[PW-1:0]];
    assign w_exp = PATTERN_BASE + DATA_WIDTH'(awh_addr >> 2);

    // R beat is presented straight from the latched request and beat index
    assign r_sum          = SW'(r_addr_q) + SW'(beat_q) * SW'(DATA_WIDTH / 8);
    assign s_axi.r_valid  = (state_q == R_BURST);
    assign s_axi.r_id     = r_id_q;
    assign s_axi.r_data   = DATA_WIDTH'(r_sum);
    assign s_axi.r_resp   = 2'b00;
    assign s_axi.r_last   = (beat_q == r_len_q);

    assign idle_o = aw_empty && b_empty && ar_empty && (state_q == R_IDLE) && (wcnt == 8'd0);

    // Queue payload writes; contents are meaningless until the pointers say otherwise
    always_ff @(posedge clk_i) begin
        if (aw_push) aw_mem[aw_wp[PW-1:0]] <= {s_axi.aw_id, s_axi.aw_addr, s_axi.aw_len};
        if (w_done)  b_mem[b_wp[PW-1:0]]   <= awh_id;
        if (ar_push) ar_mem[ar_wp[PW-1:0]] <= {s_axi.ar_id, s_axi.ar_addr, s_axi.ar_len};
    end

    // Queue pointers, W beat tracking, sticky error flags and completion counters
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            up_q        <= 1'b0;
            aw_wp       <= '0;
            aw_rp       <= '0;
            b_wp        <= '0;
            b_rp        <= '0;
            ar_wp       <= '0;
            ar_rp       <= '0;
            wcnt        <= 8'd0;
            wdata_err_o <= 1'b0;
            wlen_err_o  <= 1'b0;
            wr_cnt_o    <= 16'd0;
            rd_cnt_o    <= 16'd0;
        end else begin
            up_q <= 1'b1;
            if (aw_push) aw_wp <= aw_wp + PTR_ONE;
            if (w_done)  aw_rp <= aw_rp + PTR_ONE;
            if (w_done)  b_wp  <= b_wp + PTR_ONE;
            if (b_pop)   b_rp  <= b_rp + PTR_ONE;
            if (ar_push) ar_wp <= ar_wp + PTR_ONE;
            if (ar_pop)  ar_rp <= ar_rp + PTR_ONE;
            if (w_fire) begin
                if (s_axi.w_data != w_exp) wdata_err_o <= 1'b1;
                // WLAST ends the burst; AWLEN is only checked against it
                if ((s_axi.w_last && wcnt != awh_len) || (!s_axi.w_last && wcnt == awh_len))
                    wlen_err_o <= 1'b1;
                wcnt <= s_axi.w_last ? 8'd0 : wcnt + 8'd1;
            end
            if (b_pop)  wr_cnt_o <= wr_cnt_o + 16'd1;
            if (r_done) rd_cnt_o <= rd_cnt_o + 16'd1;
        end
    end

    // R FSM state and latched read request
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= R_IDLE;
            r_id_q   <= '0;
            r_addr_q <= '0;
            r_len_q  <= 8'd0;
            beat_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (ar_pop) begin
                r_id_q   <= arh_id;
                r_addr_q <= arh_addr;
                r_len_q  <= arh_len;
                beat_q   <= 8'd0;
            end else if (r_fire) begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    // R FSM next state: load the next request on the last beat to avoid a bubble
    always_comb begin
        state_d = state_q;
        ar_pop  = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!ar_empty) begin
                    ar_pop  = 1'b1;
                    state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_done) begin
                    if (!ar_empty) ar_pop = 1'b1;
                    else           state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_slave_responder.sv
// Directed bench for axi_slave_responder: W/B path, R path, queue full, errors, stalls, reset.
// Inputs driven 1 time unit after the rising edge; DUT outputs sampled on the falling edge.
// B and R handshakes are collected by a falling-edge monitor into queues for checking.
module tb_axi_slave_responder;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [15:0] wr_cnt, rd_cnt;
    logic        wdata_err, wlen_err, idle;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  b_q[$];   // {resp, id}
    logic [37:0] r_q[$];   // {last, id, data}
    logic [31:0] rexp [4];

    always #5 clk = ~clk;

    axi_slave_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_W_WIDTH(5), .ID_R_WIDTH(5)) bus ();

    axi_slave_responder #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_W_WIDTH(5), .ID_R_WIDTH(5),
        .FIFO_DEPTH(8), .PATTERN_BASE(32'h30)
    ) dut (
        .clk_i(clk), .arstn_i(arstn), .s_axi(bus),
        .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt),
        .wdata_err_o(wdata_err), .wlen_err_o(wlen_err), .idle_o(idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record handshakes that will complete on the next rising edge
    always @(negedge clk) begin
        if (arstn) begin
            if (bus.b_valid && bus.b_ready) b_q.push_back({bus.b_resp, bus.b_id});
            if (bus.r_valid && bus.r_ready) r_q.push_back({bus.r_last, bus.r_id, bus.r_data});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic aw_send(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len);
        int t = 0;
        @(posedge clk); #1;
        bus.aw_valid = 1'b1; bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
        @(negedge clk);
        while (!bus.aw_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("aw_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic last);
        int t = 0;
        @(posedge clk); #1;
        bus.w_valid = 1'b1; bus.w_data = data; bus.w_last = last;
        @(negedge clk);
        while (!bus.w_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("w_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.w_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [4:0] id, input logic [15:0] addr, input logic [7:0] len);
        int t = 0;
        @(posedge clk); #1;
        bus.ar_valid = 1'b1; bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
        @(negedge clk);
        while (!bus.ar_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("ar_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.w_valid = 0; bus.w_data = '0; bus.w_last = 0; bus.b_ready = 0;
        bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.r_ready = 0;

        // Reset state
        #2;
        check("rst_aw_ready", bus.aw_ready, 0);
        check("rst_ar_ready", bus.ar_ready, 0);
        check("rst_w_ready", bus.w_ready, 0);
        check("rst_b_valid", bus.b_valid, 0);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_cnts", {wr_cnt, rd_cnt}, 0);
        check("rst_errs", {wdata_err, wlen_err}, 0);
        check("rst_idle", idle, 1);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        cycles(2);
        check("up_aw_ready", bus.aw_ready, 1);
        check("up_ar_ready", bus.ar_ready, 1);
        check("w_stall_no_aw", bus.w_ready, 0);

        // 1: single 4-beat write burst
        bus.b_ready = 1'b1;
        aw_send(5'd3, 16'h8, 8'd3);
        for (int i = 0; i < 4; i++) w_send(32'h32, i == 3);
        cycles(3);
        check("t1_b_count", b_q.size(), 1);
        check("t1_b", b_q[0], {2'b00, 5'd3});
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_errs", {wdata_err, wlen_err}, 0);
        check("t1_idle", idle, 1);

        // 2: 3-beat read burst
        bus.r_ready = 1'b1;
        ar_send(5'd5, 16'h10, 8'd2);
        cycles(6);
        check("t2_r_count", r_q.size(), 3);
        check("t2_r0", r_q[0], {1'b0, 5'd5, 32'h10});
        check("t2_r1", r_q[1], {1'b0, 5'd5, 32'h14});
        check("t2_r2", r_q[2], {1'b1, 5'd5, 32'h18});
        check("t2_rd_cnt", rd_cnt, 1);
        check("t2_r_valid", bus.r_valid, 0);
        bus.r_ready = 1'b0;
        r_q.delete();

        // 3: fill AW queue, then B queue, then drain in order
        bus.b_ready = 1'b0;
        b_q.delete();
        for (int i = 0; i < 8; i++) aw_send(5'(10 + i), 16'(i * 4), 8'd0);
        check("t3_aw_full", bus.aw_ready, 0);
        check("t3_w_ready", bus.w_ready, 1);
        for (int i = 0; i < 8; i++) w_send(32'(32'h30 + i), 1'b1);
        aw_send(5'd20, 16'h20, 8'd0);
        cycles(1);
        check("t3_b_full_wstall", bus.w_ready, 0);
        check("t3_b_valid", bus.b_valid, 1);
        check("t3_not_idle", idle, 0);
        check("t3_wr_cnt_held", wr_cnt, 1);
        bus.b_ready = 1'b1;
        cycles(10);
        check("t3_b_count", b_q.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_b_order", b_q[i], {2'b00, 5'(10 + i)});
        w_send(32'h38, 1'b1);
        cycles(3);
        check("t3_b_last", b_q[8], {2'b00, 5'd20});
        check("t3_wr_cnt", wr_cnt, 10);
        check("t3_errs", {wdata_err, wlen_err}, 0);

        // 4: early WLAST with bad data, errors sticky afterwards
        b_q.delete();
        aw_send(5'd9, 16'h0, 8'd1);
        w_send(32'h99, 1'b1);
        cycles(3);
        check("t4_wlen_err", wlen_err, 1);
        check("t4_wdata_err", wdata_err, 1);
        check("t4_b", b_q[0], {2'b00, 5'd9});
        aw_send(5'd4, 16'h0, 8'd0);
        w_send(32'h30, 1'b1);
        cycles(3);
        check("t4_sticky", {wdata_err, wlen_err}, 2'b11);
        check("t4_wr_cnt", wr_cnt, 12);
        check("t4_b_count", b_q.size(), 2);

        // 5: two queued reads, RREADY toggling, zero bubble between bursts
        bus.r_ready = 1'b0;
        ar_send(5'd1, 16'h100, 8'd1);
        ar_send(5'd2, 16'h200, 8'd1);
        cycles(2);
        check("t5_hold_valid", bus.r_valid, 1);
        check("t5_hold_data", bus.r_data, 32'h100);
        check("t5_hold_id", bus.r_id, 1);
        rexp[0] = 32'h100; rexp[1] = 32'h104; rexp[2] = 32'h200; rexp[3] = 32'h204;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.r_ready = (k % 2 == 1);
            @(negedge clk);
            check("t5_valid", bus.r_valid, 1);
            check("t5_data", bus.r_data, rexp[k / 2]);
        end
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
        cycles(2);
        check("t5_r_count", r_q.size(), 4);
        check("t5_r1", r_q[1], {1'b1, 5'd1, 32'h104});
        check("t5_r2", r_q[2], {1'b0, 5'd2, 32'h200});
        check("t5_r3", r_q[3], {1'b1, 5'd2, 32'h204});
        check("t5_rd_cnt", rd_cnt, 3);
        check("t5_idle", idle, 1);

        // 6: reset mid read burst
        ar_send(5'd7, 16'h40, 8'd3);
        cycles(3);
        check("t6_r_valid_pre", bus.r_valid, 1);
        r_q.delete();
        @(posedge clk); #1;
        arstn = 1'b0;
        #2;
        check("t6_r_valid", bus.r_valid, 0);
        check("t6_cnts", {wr_cnt, rd_cnt}, 0);
        check("t6_errs", {wdata_err, wlen_err}, 0);
        check("t6_idle", idle, 1);
        bus.r_ready = 1'b1;
        @(negedge clk);
        arstn = 1'b1;
        cycles(5);
        check("t6_no_partial", r_q.size(), 0);
        check("t6_idle_after", idle, 1);
        check("t6_rd_cnt_after", rd_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
